// File: rtl/shmcp_4_pkg.sv
// Shared types and constants for the SHMCP_4 instruction sequencer.
// Holds the FSM state enum, opcode constants and the instruction classifier.
package shmcp_4_pkg;

  localparam int unsigned PROG_DEPTH = 16;

  localparam logic [3:0] OP_JNZ     = 4'h3;
  localparam logic [3:0] OP_JMP     = 4'h5;
  localparam logic [7:0] INSTR_HALT = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StHalt
  } seq_state_e;

  typedef enum logic [1:0] {
    ClsData,
    ClsJnz,
    ClsJmp,
    ClsHalt
  } instr_cls_e;

  // HALT is matched on the full byte before the opcode nibble is looked at.
  function automatic instr_cls_e classify(input logic [7:0] instr);
    instr_cls_e cls;
    if (instr == INSTR_HALT) begin
      cls = ClsHalt;
    end else if (instr[7:4] == OP_JNZ) begin
      cls = ClsJnz;
    end else if (instr[7:4] == OP_JMP) begin
      cls = ClsJmp;
    end else begin
      cls = ClsData;
    end
    return cls;
  endfunction

endpackage

// File: rtl/shmcp_4_prog_mem.sv
// Program store for the SHMCP_4 sequencer.
// Single synchronous write port and one asynchronous read port; contents are never reset.
module shmcp_4_prog_mem #(
  parameter int unsigned PROG_DEPTH = shmcp_4_pkg::PROG_DEPTH
) (
  input  logic                          i_clk,
  input  logic                          i_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] i_waddr,
  input  logic [7:0]                    i_wdata,
  input  logic [$clog2(PROG_DEPTH)-1:0] i_raddr,
  output logic [7:0]                    o_rdata
);
  import shmcp_4_pkg::*;

  logic [7:0] r_mem [PROG_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/shmcp_4_seq.sv
// SHMCP_4 instruction sequencer: program loading plus the FETCH/DECODE/EXEC walker.
// Datapath-class instructions are issued as one-cycle strobes; jumps and halts resolve here.
module shmcp_4_seq #(
  parameter int unsigned PROG_DEPTH = shmcp_4_pkg::PROG_DEPTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_state,
  input  logic                          i_load,
  input  logic [7:0]                    i_instr,
  input  logic                          i_z_in,
  output logic [$clog2(PROG_DEPTH)-1:0] o_pc,
  output logic [7:0]                    o_ir,
  output logic                          o_ex_valid,
  output logic [7:0]                    o_ex_op,
  output logic                          o_busy,
  output logic                          o_halted,
  output logic                          o_load_ovf,
  output logic [$clog2(PROG_DEPTH):0]   o_prog_len
);
  import shmcp_4_pkg::*;

  localparam int unsigned AW = $clog2(PROG_DEPTH);
  localparam logic [AW:0] PtrFull = (AW+1)'(PROG_DEPTH);

  seq_state_e r_state, w_state_next;
  logic [AW-1:0] r_pc, w_pc_next;
  logic [7:0]    r_ir, w_ir_next;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_prog_len;
  logic          r_load_ovf;

  logic          w_wr_req;
  logic          w_wr_en;
  logic [7:0]    w_rdata;
  instr_cls_e    w_cls;
  logic [AW:0]   w_pc_inc;
  logic [AW:0]   w_target;
  logic [AW:0]   w_pc_new;

  // ---------------------------------------------------------------------------
  // Program loading
  // ---------------------------------------------------------------------------
  assign w_wr_req = !i_state && i_load;
  assign w_wr_en  = w_wr_req && (r_wr_ptr < PtrFull);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_prog_len <= '0;
      r_load_ovf <= 1'b0;
    end else if (i_state) begin
      r_wr_ptr <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr   <= r_wr_ptr + 1'b1;
      r_prog_len <= r_wr_ptr + 1'b1;
    end else if (w_wr_req) begin
      r_load_ovf <= 1'b1;
    end
  end

  shmcp_4_prog_mem #(
    .PROG_DEPTH(PROG_DEPTH)
  ) u_prog_mem (
    .i_clk  (i_clk),
    .i_we   (w_wr_en),
    .i_waddr(r_wr_ptr[AW-1:0]),
    .i_wdata(i_instr),
    .i_raddr(r_pc),
    .o_rdata(w_rdata)
  );

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  assign w_cls    = classify(r_ir);
  assign w_pc_inc = {1'b0, r_pc} + 1'b1;
  assign w_target = (AW+1)'(r_ir[3:0]);

  // One bit wider than pc so that 15+1 compares as 16 against prog_len.
  always_comb begin
    w_pc_new = w_pc_inc;
    unique case (w_cls)
      ClsJnz:  w_pc_new = i_z_in ? w_pc_inc : w_target;
      ClsJmp:  w_pc_new = w_target;
      ClsData: w_pc_new = w_pc_inc;
      ClsHalt: w_pc_new = w_pc_inc;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    case (r_state)
      StIdle: begin
        if (i_state) begin
          w_state_next = (r_prog_len != '0) ? StFetch : StHalt;
        end
      end
      StFetch: begin
        w_ir_next    = w_rdata;
        w_state_next = StDecode;
      end
      StDecode: begin
        w_state_next = (w_cls == ClsHalt) ? StHalt : StExec;
      end
      StExec: begin
        // Running off the end of the store halts with pc parked on the last entry.
        if (w_pc_new < PtrFull) begin
          w_pc_next = w_pc_new[AW-1:0];
        end
        w_state_next = (w_pc_new >= r_prog_len) ? StHalt : StFetch;
      end
      StHalt: begin
        w_state_next = StHalt;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
    if (!i_state) begin
      w_state_next = StIdle;
      w_pc_next    = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_ex_valid = (r_state == StExec) && (w_cls == ClsData);
  assign o_ex_op    = o_ex_valid ? r_ir : 8'h00;
  assign o_busy     = (r_state == StFetch) || (r_state == StDecode) || (r_state == StExec);
  assign o_halted   = (r_state == StHalt);
  assign o_pc       = r_pc;
  assign o_ir       = r_ir;
  assign o_load_ovf = r_load_ovf;
  assign o_prog_len = r_prog_len;

endmodule

// File: tb/tb_shmcp_4_seq.sv
// Directed self-checking bench for the SHMCP_4 sequencer.
// Each task drives one scenario and compares against hand-computed values.
module tb_shmcp_4_seq;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_state = 1'b0;
  logic       i_load = 1'b0;
  logic [7:0] i_instr = 8'h00;
  logic       i_z_in = 1'b1;
  logic [3:0] o_pc;
  logic [7:0] o_ir;
  logic       o_ex_valid;
  logic [7:0] o_ex_op;
  logic       o_busy;
  logic       o_halted;
  logic       o_load_ovf;
  logic [4:0] o_prog_len;

  int n_checks = 0;
  int n_fail   = 0;

  // Captured ex_op pulses from the most recent run.
  logic [7:0] cap_op [32];
  int         cap_cyc [32];
  int         cap_n;
  int         cap_end;
  bit         cap_done;

  shmcp_4_seq dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_state   (i_state),
    .i_load    (i_load),
    .i_instr   (i_instr),
    .i_z_in    (i_z_in),
    .o_pc      (o_pc),
    .o_ir      (o_ir),
    .o_ex_valid(o_ex_valid),
    .o_ex_op   (o_ex_op),
    .o_busy    (o_busy),
    .o_halted  (o_halted),
    .o_load_ovf(o_load_ovf),
    .o_prog_len(o_prog_len)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    i_state = 1'b0;
    i_load  = 1'b1;
    i_instr = b;
    tick();
    i_load  = 1'b0;
  endtask

  // Runs until halted or max_cyc edges; z_in is raised after edge z_cyc.
  task automatic run_capture(input int max_cyc, input int z_cyc);
    cap_n    = 0;
    cap_end  = 0;
    cap_done = 1'b0;
    i_state  = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      if (c == z_cyc) i_z_in = 1'b1;
      if (o_ex_valid && cap_n < 32) begin
        cap_op[cap_n]  = o_ex_op;
        cap_cyc[cap_n] = c;
        cap_n++;
      end
      if (o_halted) begin
        cap_done = 1'b1;
        cap_end  = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    n_checks++;
    if ({o_pc, o_ir, o_ex_op} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_regs: pc=%h ir=%h ex_op=%h, required 0", o_pc, o_ir, o_ex_op);
    end
    n_checks++;
    if ({o_ex_valid, o_busy, o_halted, o_load_ovf} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: ev=%b busy=%b halt=%b ovf=%b, required 0",
               o_ex_valid, o_busy, o_halted, o_load_ovf);
    end
    n_checks++;
    if (o_prog_len !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_prog_len: got %0d required 0", o_prog_len);
    end
  endtask

  task automatic test_straight_line();
    logic [7:0] prog [7];
    logic [7:0] exp_op [6];
    int         exp_c [6];
    prog   = '{8'h0F, 8'h2A, 8'h41, 8'h0D, 8'h07, 8'h34, 8'h06};
    exp_op = '{8'h0F, 8'h2A, 8'h41, 8'h0D, 8'h07, 8'h06};
    exp_c  = '{3, 6, 9, 12, 15, 21};
    foreach (prog[k]) load_byte(prog[k]);
    n_checks++;
    if (o_prog_len !== 5'd7) begin
      n_fail++;
      $display("FAIL straight_prog_len: got %0d required 7", o_prog_len);
    end
    i_z_in = 1'b1;
    run_capture(60, 0);
    n_checks++;
    if (cap_done !== 1'b1 || cap_end != 22) begin
      n_fail++;
      $display("FAIL straight_halt_time: done=%b cycle=%0d, required halt at 22", cap_done, cap_end);
    end
    n_checks++;
    if (cap_n != 6) begin
      n_fail++;
      $display("FAIL straight_pulse_count: got %0d required 6", cap_n);
    end
    for (int k = 0; k < 6 && k < cap_n; k++) begin
      n_checks++;
      if (cap_op[k] !== exp_op[k] || cap_cyc[k] != exp_c[k]) begin
        n_fail++;
        $display("FAIL straight_op%0d: got %h@%0d required %h@%0d",
                 k, cap_op[k], cap_cyc[k], exp_op[k], exp_c[k]);
      end
    end
    n_checks++;
    if (o_halted !== 1'b1 || o_pc !== 4'd7 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL straight_final: halted=%b pc=%0d busy=%b, required 1/7/0",
               o_halted, o_pc, o_busy);
    end
  endtask

  task automatic test_jnz_taken();
    logic [7:0] exp_op [7];
    int         exp_c [7];
    exp_op = '{8'h0F, 8'h2A, 8'h41, 8'h0D, 8'h07, 8'h07, 8'h06};
    exp_c  = '{3, 6, 9, 12, 15, 21, 27};
    i_state = 1'b0;
    tick();
    n_checks++;
    if (o_pc !== 4'd0 || o_halted !== 1'b0 || o_prog_len !== 5'd7) begin
      n_fail++;
      $display("FAIL jnz_idle: pc=%0d halted=%b len=%0d, required 0/0/7",
               o_pc, o_halted, o_prog_len);
    end
    i_z_in = 1'b0;
    run_capture(60, 19);
    n_checks++;
    if (cap_done !== 1'b1 || cap_n != 7) begin
      n_fail++;
      $display("FAIL jnz_count: done=%b pulses=%0d, required 1/7", cap_done, cap_n);
    end
    for (int k = 0; k < 7 && k < cap_n; k++) begin
      n_checks++;
      if (cap_op[k] !== exp_op[k] || cap_cyc[k] != exp_c[k]) begin
        n_fail++;
        $display("FAIL jnz_op%0d: got %h@%0d required %h@%0d",
                 k, cap_op[k], cap_cyc[k], exp_op[k], exp_c[k]);
      end
    end
    n_checks++;
    if (o_pc !== 4'd7) begin
      n_fail++;
      $display("FAIL jnz_final_pc: got %0d required 7", o_pc);
    end
  endtask

  task automatic test_overflow();
    i_state = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) load_byte(8'(k));
    n_checks++;
    if (o_prog_len !== 5'd16 || o_load_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full: len=%0d ovf=%b, required 16/0", o_prog_len, o_load_ovf);
    end
    load_byte(8'h10);
    n_checks++;
    if (o_prog_len !== 5'd16 || o_load_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_extra: len=%0d ovf=%b, required 16/1", o_prog_len, o_load_ovf);
    end
    i_z_in = 1'b1;
    run_capture(80, 0);
    n_checks++;
    if (cap_done !== 1'b1 || cap_n != 16 || cap_end != 49) begin
      n_fail++;
      $display("FAIL ovf_run: done=%b pulses=%0d end=%0d, required 1/16/49",
               cap_done, cap_n, cap_end);
    end
    for (int k = 0; k < 16 && k < cap_n; k++) begin
      n_checks++;
      if (cap_op[k] !== 8'(k)) begin
        n_fail++;
        $display("FAIL ovf_mem%0d: got %h required %h", k, cap_op[k], 8'(k));
      end
    end
  endtask

  task automatic test_halt_abort();
    i_state = 1'b0;
    tick();
    load_byte(8'h2A);
    load_byte(8'hFF);
    load_byte(8'h41);
    n_checks++;
    if (o_prog_len !== 5'd3) begin
      n_fail++;
      $display("FAIL halt_len: got %0d required 3", o_prog_len);
    end
    run_capture(30, 0);
    n_checks++;
    if (cap_done !== 1'b1 || cap_n != 1 || cap_op[0] !== 8'h2A || cap_end != 6) begin
      n_fail++;
      $display("FAIL halt_run: done=%b pulses=%0d op0=%h end=%0d, required 1/1/2A/6",
               cap_done, cap_n, cap_op[0], cap_end);
    end
    n_checks++;
    if (o_pc !== 4'd1 || o_ir !== 8'hFF) begin
      n_fail++;
      $display("FAIL halt_hold: pc=%0d ir=%h, required 1/FF", o_pc, o_ir);
    end
    i_state = 1'b0;
    tick();
    n_checks++;
    if (o_halted !== 1'b0 || o_pc !== 4'd0 || o_busy !== 1'b0 || o_load_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle: halted=%b pc=%0d busy=%b ovf=%b, required 0/0/0/1",
               o_halted, o_pc, o_busy, o_load_ovf);
    end
  endtask

  task automatic test_reset_midrun();
    int pulses;
    load_byte(8'h2A);
    load_byte(8'h41);
    load_byte(8'h0D);
    i_state = 1'b1;
    for (int c = 1; c <= 6; c++) tick();
    n_checks++;
    if (o_ex_valid !== 1'b1 || o_ex_op !== 8'h41) begin
      n_fail++;
      $display("FAIL midrun_exec: ev=%b op=%h, required 1/41", o_ex_valid, o_ex_op);
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    n_checks++;
    if ({o_pc, o_ir, o_ex_op, o_prog_len} !== 25'h0 ||
        {o_ex_valid, o_busy, o_halted, o_load_ovf} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrun_reset: pc=%0d ir=%h op=%h len=%0d ev=%b busy=%b halt=%b ovf=%b",
               o_pc, o_ir, o_ex_op, o_prog_len, o_ex_valid, o_busy, o_halted, o_load_ovf);
    end
    tick();
    n_checks++;
    if (o_halted !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_empty_halt: halted=%b busy=%b, required 1/0", o_halted, o_busy);
    end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (o_ex_valid) pulses++;
    end
    n_checks++;
    if (pulses != 0 || o_halted !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_no_issue: pulses=%0d halted=%b, required 0/1", pulses, o_halted);
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_jnz_taken();
    test_overflow();
    test_halt_abort();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shmcp_4_seq.md
# shmcp_4_seq

Instruction sequencer for the SHMCP_4 4-bit microcoded processor. It owns the 16-entry program store, captures bytes streamed in on `instr` while in load mode, and in run mode walks the program with a FETCH/DECODE/EXEC state machine. Each datapath-class instruction is presented to the ALU/register datapath as a one-cycle execute strobe. Jumps, halt and end-of-program are resolved internally using the datapath zero flag.

## Interface
- `PROG_DEPTH`, 16: program store entries (address width `$clog2(PROG_DEPTH)`, 4 at default)
- `clk`  in  1  system clock, all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `state`  in  1  mode select: 0 = load, 1 = run
- `load`  in  1  write strobe for `instr`; honoured only when `state`=0
- `instr`  in  8  program byte to store
- `z_in`  in  1  datapath zero flag, valid during EXEC
- `pc`  out  4  program counter
- `ir`  out  8  instruction register
- `ex_valid`  out  1  datapath-class instruction executing this cycle
- `ex_op`  out  8  instruction presented to the datapath; equals `ir` when `ex_valid`=1, else 0
- `busy`  out  1  FSM in FETCH, DECODE or EXEC
- `halted`  out  1  FSM in HALT
- `load_ovf`  out  1  sticky: a write was attempted with the store already full
- `prog_len`  out  5  number of valid program entries, 0..16

## Operation
- **Instruction classes** (by `ir[7:4]`):
  - 0x3 = JNZ to address `ir[3:0]`.
  - 0x5 = JMP to address `ir[3:0]`.
  - 0xFF = HALT.
  - Everything else is datapath class and is forwarded on `ex_op`, including 0x0X register/ALU ops and 0x2X/0x4X immediate loads.
- **Load mode** (`state`=0, FSM in IDLE):
  - With `load`=1 and `wr_ptr` < 16: `mem[wr_ptr]` <= `instr`, `wr_ptr`++, `prog_len` <= `wr_ptr`+1.
  - With `load`=1 and `wr_ptr`=16: write dropped, `load_ovf` <= 1.
  - `wr_ptr` is cleared in every cycle with `state`=1, so the next load session overwrites from address 0.
- **FSM states:** IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE -> FETCH when `state`=1 and `prog_len`>0. IDLE -> HALT when `state`=1 and `prog_len`=0.
  - FETCH: `ir` <= `mem[pc]`; go to DECODE.
  - DECODE: classify `ir`; go to EXEC, or HALT for 0xFF.
  - EXEC:
    - Datapath class: `ex_valid`=1 and `pc`+1.
    - JNZ: `pc` <= `ir[3:0]` if `z_in`=0, else `pc`+1.
    - JMP: `pc` <= `ir[3:0]`.
    - Next state is HALT if the new `pc` >= `prog_len`, else FETCH.
  - HALT: hold `pc` and `ir`.
  - Any state -> IDLE when `state`=0; `pc` <= 0 and `halted` clears. This applies mid-instruction; an aborted EXEC still completes its single `ex_valid` cycle.
- **PC width:** `pc` is 4 bits. `pc`+1 from 15 produces a 5-bit compare value of 16, which is >= `prog_len`, so the FSM halts rather than wrapping.
- **Jump targets:** a target >= `prog_len` halts immediately; no fetch is performed.
- **Reset:** all outputs and `wr_ptr` go to 0 and the FSM goes to IDLE. Program store contents are not cleared, but `prog_len`=0 makes them unreachable.

## Timing
- Every instruction takes 3 cycles: FETCH, DECODE, EXEC.
- `ex_valid` and `ex_op` are Moore outputs decoded from the state register and `ir`, held for exactly the EXEC cycle.
- First `ex_valid` is in the 3rd cycle after the edge that samples `state`=1 in IDLE.
- Consecutive `ex_valid` pulses are 3 cycles apart.
- `z_in` is sampled at the rising edge ending a JNZ EXEC. The datapath must update `z_in` by the end of the preceding datapath EXEC.
- Program store: synchronous write, combinational read into `ir` on FETCH.
- `state` and `load` are sampled each rising edge. There is no other handshake.

## Structure
- Shared package `shmcp_4_pkg`:
  - FSM state enum.
  - Opcode nibble constants: `OP_JNZ`=3, `OP_JMP`=5.
  - `INSTR_HALT`=8'hFF.
  - `PROG_DEPTH`.
- Sub-module `shmcp_4_prog_mem`: PROG_DEPTH x 8, one write port, one async read port, no reset.
- Top level contains the FSM, `pc`, `ir`, `wr_ptr`, `prog_len` and `load_ovf`.

## Test plan
1. **Reset:** `rst`=1 for 2 cycles -> all outputs 0, FSM in IDLE, `busy`=0.
2. **Straight-line run:**
   - Stimulus: load 0F,2A,41,0D,07,34,06, then `state`=1 with `z_in`=1.
   - Required: `prog_len`=7; `ex_op` sequence 0F,2A,41,0D,07,06, each 3 cycles apart; no pulse for 0x34; `halted`=1 with `pc`=7.
3. **JNZ taken:**
   - Stimulus: same program; `z_in`=0 on the first JNZ EXEC, 1 on the second.
   - Required: `ex_op` after the first 0x34 is 07 (`pc`=4), then 06 after the second JNZ, then halt.
4. **Overflow:**
   - Stimulus: load 17 bytes 0x00..0x10.
   - Required: `prog_len`=16, `load_ovf`=1, `mem[15]`=0x0F, 0x10 discarded.
5. **HALT and abort:**
   - Stimulus: program 2A,FF,41 run, then `state`=0.
   - Required: only 2A issued, `halted`=1, `pc`=1; one cycle after `state`=0 the FSM is in IDLE with `pc`=0 and `halted`=0.
6. **Reset mid-run:**
   - Stimulus: `rst` during the EXEC of the 2nd instruction, then `state`=1.
   - Required: next cycle all outputs 0. `prog_len`=0, so the FSM goes IDLE -> HALT with no `ex_valid`.
